// File: rtl/reg_file_param_if.sv
// Bus bundle for the two-read/one-write register file.
// The master drives the write port and read addresses.
// The slave (the register file) returns read data and the init status.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              reg_write;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              init_busy;

  modport master (
    output reg_write, write_register, write_data, read_reg_1, read_reg_2,
    input  read_data_1, read_data_2, init_busy
  );

  modport slave (
    input  reg_write, write_register, write_data, read_reg_1, read_reg_2,
    output read_data_1, read_data_2, init_busy
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised 2R/1W register file for the KGP-RISC datapath.
// After reset, a hardware sweep loads every register with its own index.
// Writes are ignored and reads return 0 until the sweep completes.
// Reads are combinational, with a same-cycle bypass from the write port.
// Optional macro ZERO_REG_EN hardwires register 0 to zero:
// writes to it are dropped, and reads of it return 0 without bypass.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input logic             clk,
  input logic             rst,
  reg_file_param_if.slave bus
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // The pointer is one bit wider than an address.
  // This keeps NUM_REGS == 2**ADDR_W representable, so the compare never wraps.
  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t LAST_PTR = ptr_t'(NUM_REGS - 1);
  localparam ptr_t NREGS_P  = ptr_t'(NUM_REGS);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  ptr_t              ptr_q, ptr_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic              init_busy;
  logic              sweep_en;
  logic              wr_legal;
  logic [DATA_W-1:0] sweep_data;

  // Sweep value is the pointer, zero-extended or truncated to the data width.
  generate
    if (DATA_W > ADDR_W + 1) begin : g_sweep_ext
      assign sweep_data = {{(DATA_W - ADDR_W - 1){1'b0}}, ptr_q};
    end else begin : g_sweep_trunc
      assign sweep_data = ptr_q[DATA_W-1:0];
    end
  endgenerate

  // State register: reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: advance the sweep; leave INIT after the last entry is written.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
    endcase
  end

  // Outputs of the FSM: busy flag, sweep strobe and write qualification.
  // Reset blocks both sweep and user writes, so the array is untouched during reset.
  always_comb begin
    init_busy = (state_q == ST_INIT);
    sweep_en  = init_busy & ~rst;
    wr_legal  = ~rst & (state_q == ST_READY) & bus.reg_write
              & ({1'b0, bus.write_register} < NREGS_P)
              & ~(ZERO_REG & (bus.write_register == '0));
  end

  // Array update: the sweep owns the array in INIT; user writes apply only in READY.
  always_ff @(posedge clk) begin
    if (sweep_en) begin
      rf_q[ptr_q[ADDR_W-1:0]] <= sweep_data;
    end else if (wr_legal) begin
      rf_q[bus.write_register] <= bus.write_data;
    end
  end

  // Both read ports share the same logic.
  // Each port independently decides between zero, bypass, and array data.
  logic [ADDR_W-1:0] rd_addr [2];
  assign rd_addr[0] = bus.read_reg_1;
  assign rd_addr[1] = bus.read_reg_2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] rd_data;
      logic              in_range;
      logic              is_zero_reg;

      assign in_range    = ({1'b0, rd_addr[gi]} < NREGS_P);
      assign is_zero_reg = ZERO_REG & (rd_addr[gi] == '0);

      // Read mux: zero while busy or out of range, else bypass or array data.
      always_comb begin
        rd_data = '0;
        if (!init_busy && in_range && !is_zero_reg) begin
          if (wr_legal && (bus.write_register == rd_addr[gi])) begin
            rd_data = bus.write_data;
          end else begin
            rd_data = rf_q[rd_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign bus.read_data_1 = g_rd[0].rd_data;
  assign bus.read_data_2 = g_rd[1].rd_data;
  assign bus.init_busy   = init_busy;

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised two-read/one-write register file for the KGP-RISC datapath; successor to the fixed 32x32 register file.
- Configurable data width and register count.
- Registers are initialised by a hardware sweep after reset instead of an initial block.
- Same-cycle write-to-read bypass, so the decode stage sees a value written in the same cycle.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of implemented registers; must be ≤ 2**ADDR_W and ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- reg_write  input  1  write enable.
- write_register  input  ADDR_W  write address.
- write_data  input  DATA_W  write data.
- read_reg_1  input  ADDR_W  read port 1 address.
- read_reg_2  input  ADDR_W  read port 2 address.
- read_data_1  output  DATA_W  read port 1 data (combinational).
- read_data_2  output  DATA_W  read port 2 data (combinational).
- init_busy  output  1  high while the init sweep runs; writes are ignored and reads return 0.

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-high, sampled on posedge clk.
  - While rst=1: state=INIT, sweep pointer ptr=0, init_busy=1. Array contents are not written during reset.
- FSM states INIT and READY:
  - INIT with rst=0: each posedge writes RF[ptr] <= ptr, zero-extended or truncated to DATA_W, then ptr <= ptr+1.
  - On the posedge that writes ptr=NUM_REGS-1: state <= READY and init_busy <= 0.
  - init_busy is therefore high for exactly NUM_REGS cycles after rst deasserts.
  - READY: stays in READY until rst is asserted. rst in READY returns the FSM to INIT with ptr=0 on the next posedge.
  - rst asserted mid-sweep restarts the sweep from ptr=0. Already-written entries are rewritten.
- Write:
  - Takes effect only in READY when reg_write=1 and write_register < NUM_REGS: RF[write_register] <= write_data on posedge.
  - An out-of-range write address drops the write silently.
  - Writes in INIT are dropped.
- Read:
  - Combinational.
  - read_data_n = 0 if init_busy=1 or read_reg_n ≥ NUM_REGS.
  - Otherwise, if reg_write=1, write_register==read_reg_n, and the write is legal (READY, in range): read_data_n = write_data (bypass).
  - Otherwise read_data_n = RF[read_reg_n].
  - The two ports are independent; both may read the same address, and both may bypass at once.
- Timing: read latency 0 cycles; write visible via the array on the cycle after the posedge, and via the bypass in the same cycle.
- Output reset values: init_busy=1; read_data_1=read_data_2=0.
- Widths: ptr is ADDR_W+1 bits so NUM_REGS=2**ADDR_W terminates without wrap. No arithmetic on data.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero: writes to address 0 are dropped, and reads of address 0 return 0 with no bypass.
  - The sweep writes 0 to RF[0], unchanged from undefined.
- Not defined: register 0 is an ordinary register. The sweep loads it with 0 and it is writable and bypassable like any other.

Test Plan:
- rst=1 for 2 cycles, then 0 -> init_busy=1 for exactly 32 cycles, and read_data_1=0 throughout. Afterwards read_reg_1=5, read_reg_2=31 -> read_data_1=5, read_data_2=31.
- READY, reg_write=1, write_register=7, write_data=0xDEADBEEF, read_reg_1=7 in the same cycle -> read_data_1=0xDEADBEEF combinationally (bypass). On the next cycle, with reg_write=0, read_data_1 still 0xDEADBEEF.
- reg_write=1 with write_register=3 during INIT (cycle 10 of the sweep) -> write dropped; after init, RF[3] reads 3.
- rst pulsed for 1 cycle at sweep cycle 15 -> init_busy stays high for 32 further cycles, and all registers read their index afterwards.
- NUM_REGS=20, ADDR_W=5: write 0x55 to address 25, then read address 25 -> 0; RF[0..19] unchanged.
- ZERO_REG_EN defined: write 0x1234 to address 0 with read_reg_2=0 -> read_data_2=0 in the same cycle and the next. Without the macro -> 0x1234 in both cycles.
